// File: rtl/core_pkg.sv
// core_pkg: shared core constants and register-index types.
// Provides default widths, reg_idx_t and the x0 index constant.
package core_pkg;

   localparam int N_BITS_DEFAULT = 32;
   localparam int N_REGS_DEFAULT = 32;
   localparam int N_IDX_DEFAULT  = $clog2(N_REGS_DEFAULT);

   typedef logic [N_IDX_DEFAULT-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/opfetch_scoreboard.sv
// opfetch_scoreboard: per-register pending bits for in-flight writes.
// Ports: set_en_i/set_idx_i (issue), wb_en_i/wb_idx_i (writeback clear),
//   fl_en_i/fl_idx_i (flush clear), pend_o (raw bits), ep_o (effective).
// Macro OPFETCH_WB_BYPASS_EN: ep_o hides the register written back now.
module opfetch_scoreboard
   import core_pkg::*;
#(
   parameter  int N_REGS = N_REGS_DEFAULT,
   localparam int N_IDX  = $clog2(N_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en_i,
   input  logic [N_IDX-1:0]  set_idx_i,
   input  logic              wb_en_i,
   input  logic [N_IDX-1:0]  wb_idx_i,
   input  logic              fl_en_i,
   input  logic [N_IDX-1:0]  fl_idx_i,
   output logic [N_REGS-1:0] pend_o,
   output logic [N_REGS-1:0] ep_o
);

   logic [N_REGS-1:0] pend_q;
   logic [N_REGS-1:0] pend_d;
   logic [N_REGS-1:0] set_v;
   logic [N_REGS-1:0] wb_v;
   logic [N_REGS-1:0] fl_v;

   // x0 never gets a pending bit, so its decode lines are forced low.
   always_comb begin
      set_v = '0;
      wb_v  = '0;
      fl_v  = '0;
      for (int i = 1; i < N_REGS; i++) begin
         set_v[i] = set_en_i && (set_idx_i == N_IDX'(i));
         wb_v[i]  = wb_en_i  && (wb_idx_i  == N_IDX'(i));
         fl_v[i]  = fl_en_i  && (fl_idx_i  == N_IDX'(i));
      end
   end

   // A new issue overrides any clear on the same register.
   always_comb begin
      pend_d = set_v | (pend_q & ~(wb_v | fl_v));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

`ifdef OPFETCH_WB_BYPASS_EN
   assign ep_o = pend_q & ~wb_v;
`else
   assign ep_o = pend_q;
`endif

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch/issue stage between decode and execute.
// Ports: in_* (decode uop, valid/ready), rf_rd* (regfile read ports),
//   wb_* (writeback), flush, out_* (execute bundle, valid/ready).
// Macro OPFETCH_WB_BYPASS_EN: forward same-cycle wb_data into operands.
module operand_fetch
   import core_pkg::*;
#(
   parameter  int N_BITS = N_BITS_DEFAULT,
   parameter  int N_REGS = N_REGS_DEFAULT,
   localparam int N_IDX  = $clog2(N_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IDX-1:0]  in_rs1_idx,
   input  logic [N_IDX-1:0]  in_rs2_idx,
   input  logic              in_uses_rs1,
   input  logic              in_uses_rs2,
   input  logic [N_IDX-1:0]  in_rd_idx,
   input  logic              in_rd_wen,
   output logic [N_IDX-1:0]  rf_rd0_idx,
   output logic [N_IDX-1:0]  rf_rd1_idx,
   input  logic [N_BITS-1:0] rf_rd0_data,
   input  logic [N_BITS-1:0] rf_rd1_data,
   input  logic              wb_en,
   input  logic [N_IDX-1:0]  wb_idx,
   input  logic [N_BITS-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_BITS-1:0] out_rs1_data,
   output logic [N_BITS-1:0] out_rs2_data,
   output logic [N_IDX-1:0]  out_rd_idx,
   output logic              out_rd_wen
);

   localparam logic [N_IDX-1:0] ZIDX = N_IDX'(REG_ZERO);

   logic [N_REGS-1:0] pend;
   logic [N_REGS-1:0] ep;
   logic              hazard;
   logic              accept;
   logic              rd_wen_eff;
   logic              fl_clr;

   logic              valid_q, valid_d;
   logic [N_BITS-1:0] rs1_q, rs1_d;
   logic [N_BITS-1:0] rs2_q, rs2_d;
   logic [N_IDX-1:0]  rd_q, rd_d;
   logic              rdw_q, rdw_d;

   assign rf_rd0_idx = in_rs1_idx;
   assign rf_rd1_idx = in_rs2_idx;

   assign rd_wen_eff = in_rd_wen && (in_rd_idx != ZIDX);
   assign fl_clr     = flush && valid_q && rdw_q;

   opfetch_scoreboard #(
      .N_REGS (N_REGS)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en_i  (accept && rd_wen_eff),
      .set_idx_i (in_rd_idx),
      .wb_en_i   (wb_en),
      .wb_idx_i  (wb_idx),
      .fl_en_i   (fl_clr),
      .fl_idx_i  (rd_q),
      .pend_o    (pend),
      .ep_o      (ep)
   );

   // WAW is checked on the raw rd_wen; ep[0] is always 0 anyway.
   assign hazard = (in_uses_rs1 && ep[in_rs1_idx])
                || (in_uses_rs2 && ep[in_rs2_idx])
                || (in_rd_wen   && ep[in_rd_idx]);

   assign in_ready = !hazard && !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // x0 reads 0 because the regfile array does not hardwire it.
   function automatic logic [N_BITS-1:0] opnd(
      input logic [N_IDX-1:0]  idx,
      input logic [N_BITS-1:0] rf
   );
      logic [N_BITS-1:0] r;
      r = rf;
      if (idx == ZIDX) begin
         r = '0;
`ifdef OPFETCH_WB_BYPASS_EN
      end else if (wb_en && (wb_idx == idx)) begin
         r = wb_data;
`endif
      end
      return r;
   endfunction

`ifndef OPFETCH_WB_BYPASS_EN
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
`endif

   logic unused_pend;
   assign unused_pend = ^pend;

   always_comb begin
      rs1_d = rs1_q;
      rs2_d = rs2_q;
      rd_d  = rd_q;
      rdw_d = rdw_q;
      if (accept) begin
         rs1_d = in_uses_rs1 ? opnd(in_rs1_idx, rf_rd0_data) : '0;
         rs2_d = in_uses_rs2 ? opnd(in_rs2_idx, rf_rd1_data) : '0;
         rd_d  = in_rd_idx;
         rdw_d = rd_wen_eff;
      end
   end

   // Flush kills the held uop; in_ready is low then, so no accept.
   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         rdw_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         rdw_q   <= rdw_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_rs1_data = rs1_q;
   assign out_rs2_data = rs2_q;
   assign out_rd_idx   = rd_q;
   assign out_rd_wen   = rdw_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench with a regfile/scoreboard model.
// Follows OPFETCH_WB_BYPASS_EN when defined.
module tb_operand_fetch;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
   logic        in_uses_rs1, in_uses_rs2, in_rd_wen;
   logic [4:0]  rf_rd0_idx, rf_rd1_idx;
   logic [31:0] rf_rd0_data, rf_rd1_data;
   logic        wb_en;
   logic [4:0]  wb_idx;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_rs1_data, out_rs2_data;
   logic [4:0]  out_rd_idx;
   logic        out_rd_wen;

   int checks = 0;
   int failures = 0;

`ifdef OPFETCH_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   operand_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rs1_idx   (in_rs1_idx),
      .in_rs2_idx   (in_rs2_idx),
      .in_uses_rs1  (in_uses_rs1),
      .in_uses_rs2  (in_uses_rs2),
      .in_rd_idx    (in_rd_idx),
      .in_rd_wen    (in_rd_wen),
      .rf_rd0_idx   (rf_rd0_idx),
      .rf_rd1_idx   (rf_rd1_idx),
      .rf_rd0_data  (rf_rd0_data),
      .rf_rd1_data  (rf_rd1_data),
      .wb_en        (wb_en),
      .wb_idx       (wb_idx),
      .wb_data      (wb_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rs1_data (out_rs1_data),
      .out_rs2_data (out_rs2_data),
      .out_rd_idx   (out_rd_idx),
      .out_rd_wen   (out_rd_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: regfile contents, pending set, and the execute-side register.
   logic [31:0] m_rf [32];
   bit          m_pend [32];
   logic        m_valid, m_rdw;
   logic [31:0] m_rs1, m_rs2;
   logic [4:0]  m_rd;

   assign rf_rd0_data = m_rf[rf_rd0_idx];
   assign rf_rd1_data = m_rf[rf_rd1_idx];

   function automatic bit m_ep(input logic [4:0] i);
      return m_pend[i] && !(BYP && wb_en && wb_idx == i);
   endfunction

   function automatic bit m_ready();
      bit hz;
      hz = (in_uses_rs1 && m_ep(in_rs1_idx))
        || (in_uses_rs2 && m_ep(in_rs2_idx))
        || (in_rd_wen && m_ep(in_rd_idx));
      return !hz && !flush && (!m_valid || out_ready);
   endfunction

   function automatic logic [31:0] m_opnd(input logic [4:0] i, input bit u);
      if (!u || i == 0) return 32'h0;
      if (BYP && wb_en && wb_idx == i) return wb_data;
      return m_rf[i];
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit acc;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_pend[i] <= 1'b0;
            m_rf[i]   <= 32'h100 + i;
         end
         m_rf[0] <= 32'hFFFF;
         m_rf[1] <= 32'd5;
         m_rf[2] <= 32'd7;
         m_valid <= 1'b0;
         m_rs1   <= '0;
         m_rs2   <= '0;
         m_rd    <= '0;
         m_rdw   <= 1'b0;
      end else begin
         acc = in_valid && m_ready();
         if (wb_en) m_pend[wb_idx] <= 1'b0;
         if (flush && m_valid && m_rdw) m_pend[m_rd] <= 1'b0;
         if (acc && in_rd_wen && in_rd_idx != 0) m_pend[in_rd_idx] <= 1'b1;
         if (flush) begin
            m_valid <= 1'b0;
         end else if (acc) begin
            m_valid <= 1'b1;
            m_rs1   <= m_opnd(in_rs1_idx, in_uses_rs1);
            m_rs2   <= m_opnd(in_rs2_idx, in_uses_rs2);
            m_rd    <= in_rd_idx;
            m_rdw   <= in_rd_wen && in_rd_idx != 0;
         end else if (out_ready) begin
            m_valid <= 1'b0;
         end
         if (wb_en) m_rf[wb_idx] <= wb_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cmp_in_ready", 32'(in_ready), 32'(m_ready()));
         chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("cmp_rs1", out_rs1_data, m_rs1);
            chk("cmp_rs2", out_rs2_data, m_rs2);
            chk("cmp_rd_idx", 32'(out_rd_idx), 32'(m_rd));
            chk("cmp_rd_wen", 32'(out_rd_wen), 32'(m_rdw));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic uop(input bit v, input logic [4:0] r1, input bit u1,
                      input logic [4:0] r2, input bit u2,
                      input logic [4:0] rd, input bit w);
      in_valid    = v;
      in_rs1_idx  = r1;
      in_uses_rs1 = u1;
      in_rs2_idx  = r2;
      in_uses_rs2 = u2;
      in_rd_idx   = rd;
      in_rd_wen   = w;
   endtask

   task automatic wb(input bit e, input logic [4:0] i, input logic [31:0] d);
      wb_en   = e;
      wb_idx  = i;
      wb_data = d;
   endtask

   initial begin
      rst_n = 1'b0;
      uop(0, 0, 0, 0, 0, 0, 0);
      wb(0, 0, 0);
      flush = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rs1", out_rs1_data, 32'd0);
      chk("rst_rs2", out_rs2_data, 32'd0);
      chk("rst_rd_idx", 32'(out_rd_idx), 32'd0);
      chk("rst_rd_wen", 32'(out_rd_wen), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Basic read of x1/x2.
      uop(1, 1, 1, 2, 1, 0, 0);
      cyc();
      in_valid = 1'b0;
      #1;
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_rs1", out_rs1_data, 32'd5);
      chk("t1_rs2", out_rs2_data, 32'd7);
      cyc();

      // RAW stall on x3, released by writeback 0xAB.
      uop(1, 0, 0, 0, 0, 3, 1);
      cyc();
      uop(1, 3, 1, 0, 0, 0, 0);
      #1 chk("t2_stall0", 32'(in_ready), 32'd0);
      cyc();
      #1 chk("t2_stall1", 32'(in_ready), 32'd0);
      cyc();
      wb(1, 3, 32'hAB);
      #1;
      if (BYP) begin
         chk("t2_byp_ready", 32'(in_ready), 32'd1);
         cyc();
         wb(0, 0, 0);
         in_valid = 1'b0;
      end else begin
         chk("t2_wb_stall", 32'(in_ready), 32'd0);
         cyc();
         wb(0, 0, 0);
         #1 chk("t2_after_wb", 32'(in_ready), 32'd1);
         cyc();
         in_valid = 1'b0;
      end
      #1;
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_rs1", out_rs1_data, 32'hAB);
      cyc();

      // x0 source and x0 destination.
      uop(1, 0, 1, 0, 0, 0, 1);
      cyc();
      #1;
      chk("t3_rs1_zero", out_rs1_data, 32'd0);
      chk("t3_rd_wen", 32'(out_rd_wen), 32'd0);
      chk("t3_no_pend0", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      cyc();

      // Backpressure: hold for 3 cycles, then release.
      out_ready = 1'b0;
      uop(1, 1, 1, 0, 0, 0, 0);
      cyc();
      uop(1, 2, 1, 0, 0, 6, 1);
      repeat (3) begin
         #1;
         chk("t4_hold_ready", 32'(in_ready), 32'd0);
         chk("t4_hold_rs1", out_rs1_data, 32'd5);
         cyc();
      end
      out_ready = 1'b1;
      #1 chk("t4_release", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      #1;
      chk("t4_next_rs1", out_rs1_data, 32'd7);
      chk("t4_next_rd", 32'(out_rd_idx), 32'd6);
      wb(1, 6, 32'h66);
      cyc();
      wb(0, 0, 0);

      // Flush of a held rd=5 writer.
      out_ready = 1'b0;
      uop(1, 0, 0, 0, 0, 5, 1);
      cyc();
      uop(1, 5, 1, 0, 0, 0, 0);
      flush = 1'b1;
      #1 chk("t5_flush_ready", 32'(in_ready), 32'd0);
      cyc();
      flush = 1'b0;
      #1;
      chk("t5_flushed", 32'(out_valid), 32'd0);
      chk("t5_no_stall", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1 chk("t5_rs1", out_rs1_data, 32'h105);
      cyc();

      // WAW on x4, then issue alongside its writeback.
      uop(1, 0, 0, 0, 0, 4, 1);
      cyc();
      #1 chk("t6_waw", 32'(in_ready), 32'd0);
      cyc();
      wb(1, 4, 32'h44);
      #1;
      if (BYP) begin
         chk("t6_byp_issue", 32'(in_ready), 32'd1);
         cyc();
         wb(0, 0, 0);
      end else begin
         chk("t6_wb_stall", 32'(in_ready), 32'd0);
         cyc();
         wb(0, 0, 0);
         #1 chk("t6_issue", 32'(in_ready), 32'd1);
         cyc();
      end
      uop(1, 4, 1, 0, 0, 0, 0);
      #1 chk("t6_still_pend", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      wb(1, 4, 32'h45);
      cyc();
      wb(0, 0, 0);
      cyc();

      // Back-to-back hazard-free stream.
      for (int k = 0; k < 8; k++) begin
         uop(1, 5'(k + 1), 1, 5'(k + 9), 1, 5'(k + 20), 1);
         #1 chk("t7_b2b", 32'(in_ready), 32'd1);
         cyc();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wb(1, 5'(k + 20), 32'(k));
         cyc();
      end
      wb(0, 0, 0);
      uop(1, 20, 1, 27, 1, 0, 0);
      #1 chk("t7_cleared", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      cyc();

      // Reset in the middle of a held writer.
      out_ready = 1'b0;
      uop(1, 0, 0, 0, 0, 7, 1);
      cyc();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t8_rst_valid", 32'(out_valid), 32'd0);
      chk("t8_rst_rd_wen", 32'(out_rd_wen), 32'd0);
      chk("t8_rst_rd_idx", 32'(out_rd_idx), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      uop(1, 7, 1, 0, 0, 0, 0);
      #1 chk("t8_no_pend", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch/issue stage of the RISC-V core. It sits directly downstream of decode and drives the two read ports of the 32-entry register file. It tracks in-flight register writes with a per-register pending scoreboard and stalls on RAW/WAW hazards. It bypasses same-cycle writeback data and registers the operands into a valid/ready pipeline register feeding execute.

## Interface
Parameters:
- N_BITS, 32, data width
- N_REGS, 32, architectural register count
- N_IDX, $clog2(N_REGS), index width (localparam)

Ports:
- clk  in  1  core clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode has a uop
- in_ready  out  1  uop accepted this cycle when in_valid && in_ready
- in_rs1_idx, in_rs2_idx  in  N_IDX  source indices
- in_uses_rs1, in_uses_rs2  in  1  source actually read
- in_rd_idx  in  N_IDX  destination index
- in_rd_wen  in  1  uop writes rd
- rf_rd0_idx, rf_rd1_idx  out  N_IDX  regfile read indices; combinational copies of in_rs1_idx/in_rs2_idx
- rf_rd0_data, rf_rd1_data  in  N_BITS  regfile read data; asynchronous read
- wb_en  in  1  writeback this cycle; the parent also routes this write to the regfile
- wb_idx  in  N_IDX  writeback index
- wb_data  in  N_BITS  writeback data
- flush  in  1  kill the uop held in the output register
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_rs1_data, out_rs2_data  out  N_BITS  resolved operands
- out_rd_idx  out  N_IDX  destination
- out_rd_wen  out  1  destination write enable; never 1 for x0

## Operation
- Scoreboard: pending[N_REGS] bits. Set on accept when in_rd_wen && in_rd_idx!=0. Cleared when wb_en at wb_idx.
- Effective pending ep[i] = pending[i] && !(wb_en && wb_idx==i), with bypass enabled.
- hazard = (in_uses_rs1 && ep[rs1]) || (in_uses_rs2 && ep[rs2]) || (in_rd_wen && ep[rd]).
- The WAW check guarantees at most one in-flight writer per register.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Operand select, per source, highest priority first:
  - index 0 → 0, because the regfile does not hardwire x0
  - wb_en && wb_idx==idx → wb_data
  - otherwise rf data
- Sources with uses_rsN=0 are registered as 0.
- out_rd_wen = in_rd_wen && in_rd_idx!=0.
- flush: out_valid←0. If out_valid && out_rd_wen, also clear pending[out_rd_idx]. Flush wins over accept in the same cycle.
- Same-cycle set and clear on the same index (issue and wb): set wins.
- flush-clear and wb-clear on the same index: cleared.
- wb_en with wb_idx=0 is ignored.

## Timing
- Latency: 1 cycle, accept at edge N → out_valid from N.
- Output register loads on accept.
- Output register holds stable while out_valid && !out_ready.
- out_valid drops after a transfer with no new accept.
- Back-to-back throughput: 1 uop/cycle when hazard-free.
- Reset, asynchronous: out_valid=0, out_rs1/rs2_data=0, out_rd_idx=0, out_rd_wen=0, pending=all 0.
- After reset: in_ready=1 whenever flush=0.
- Reset mid-operation discards the held uop and all pending bits.

## Configuration
- OPFETCH_WB_BYPASS_EN defined: same-cycle wb_data forwarding, and ep excludes the register being written back. A dependent uop issues in the writeback cycle.
- OPFETCH_WB_BYPASS_EN undefined: ep = pending, with no forwarding mux. A dependent uop stalls until the cycle after writeback and reads the regfile.

## Structure
- core_pkg: N_BITS_DEFAULT, N_REGS_DEFAULT, reg_idx_t typedef, and the x0 index constant REG_ZERO.
- Sub-module opfetch_scoreboard holds:
  - the pending array
  - set, wb-clear and flush-clear ports
  - the ep vector output

## Test plan
- Reset, then issue rs1=1, rs2=2 with x1=5, x2=7 → out_valid next cycle, out_rs1_data=5, out_rs2_data=7, pending unchanged.
- Issue rd=3, then a dependent uop rs1=3 → in_ready=0 until wb_en at idx 3 with 0xAB. With bypass: accepted that cycle, out_rs1_data=0xAB. Without bypass: accepted one cycle later.
- Issue rs1=0, rd=0, rd_wen=1 with rf x0 holding 0xFFFF → out_rs1_data=0, out_rd_wen=0, pending[0] stays 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. out_ready=1 → next uop loads the following cycle.
- Uop rd=5 held in the output register, flush=1 with in_valid=1 → out_valid=0, pending[5]=0, input not accepted. The next uop with rs1=5 issues without stall.
- Issue rd=4 while older writer of x4 is pending → stall (WAW). wb idx 4 and issue same cycle → pending[4]=1 afterwards.
